decode_stage_hz: RTL
====================

DECODE_STAGE_HZ -- requirements
Module: decode_stage_hz

Interface
REQ-001 SHALL take parameter DWIDTH, 32, data/register width.
REQ-002 SHALL take parameter NREGS, 32, register count (power of two, min 8); AWIDTH = log2(NREGS).
REQ-003 SHALL take parameter IWIDTH, 32, instruction width (MIPS-I field layout).
REQ-004 SHALL have ports:
ds_clk  in  1  clock
ds_rst  in  1  asynchronous active-high reset
ds_i_ce  in  1  instruction valid from fetch
ds_i_instr  in  IWIDTH  instruction
ds_i_flush  in  1  branch/jump taken; kill decode
ds_i_reg_wr  in  1  writeback enable
ds_i_addr_rd  in  AWIDTH  writeback address
ds_i_data_rd  in  DWIDTH  writeback data
ds_o_stall  out  1  hold fetch and IF/ID
ds_o_ce  out  1  ID/EX valid
ds_o_opcode  out  6  registered opcode
ds_o_funct  out  6  registered funct
ds_o_data_rs, ds_o_data_rt  out  DWIDTH  registered operands
ds_o_addr_rs, ds_o_addr_rt, ds_o_addr_rd  out  AWIDTH  registered addresses (addr_rd = resolved destination)
ds_o_imm  out  DWIDTH  sign-extended immediate
ds_o_jal_addr  out  26  jump target field
ds_o_reg_wr, ds_o_memwrite, ds_o_memtoreg, ds_o_alu_src, ds_o_branch, ds_o_jal, ds_o_jr  out  1 each  registered controls

Function
REQ-005 SHALL register all outputs except ds_o_stall into an ID/EX stage; decode-to-output latency one cycle.
REQ-006 SHALL decode: R-type(op 0) reg_wr=1, dest=rd, jr when funct 0x08 (reg_wr=0); lw(0x23) memtoreg=1, alu_src=1, reg_wr=1, dest=rt; sw(0x2B) memwrite=1, alu_src=1; beq(0x04) branch=1; addi(0x08) alu_src=1, reg_wr=1, dest=rt; jal(0x03) jal=1, reg_wr=1, dest=NREGS-1; other opcodes all controls 0.
REQ-007 SHALL sign-extend instr[15:0] to DWIDTH.
REQ-008 SHALL hold NREGS x DWIDTH register file, written on rising edge when ds_i_reg_wr=1 and ds_i_addr_rd!=0.
REQ-009 SHALL read register 0 as zero always.
REQ-010 SHALL bypass same-cycle writeback: read address equal to nonzero ds_i_addr_rd with ds_i_reg_wr=1 returns ds_i_data_rd.
REQ-011 SHALL assert ds_o_stall combinationally when ds_i_ce=1, ds_o_ce=1, ds_o_memtoreg=1, ds_o_addr_rd!=0, and ds_o_addr_rd equals incoming rs, or incoming rt for R-type/beq/sw.
REQ-012 SHALL, on stall, load a bubble (ds_o_ce=0, all controls 0) into ID/EX; decode inputs are re-presented next cycle by fetch.
REQ-013 SHALL, when ds_i_flush=1, load a bubble and force ds_o_stall=0; flush has priority over stall.
REQ-014 SHALL load a bubble when ds_i_ce=0.
REQ-015 SHALL clear a stall after exactly one bubble for a single load-use dependency.

Reset
REQ-016 SHALL, on ds_rst=1 asynchronously, clear every ID/EX output to 0 (ds_o_ce=0) and all registers to 0.
REQ-017 SHALL hold ds_o_stall=0 while ds_rst=1.
REQ-018 SHALL resume normal decode on the first rising edge after reset release; reset mid-stall discards the pending instruction.

Structure
REQ-019 SHALL take opcode/funct constants, field widths and control-bundle layout from the shared header/package.
REQ-020 SHALL instantiate one combinational sub-module ds_ctrl_decode (REQ-006/007); register file, bypass, hazard and ID/EX logic in decode_stage_hz.

Verification
REQ-021 SHALL check reset: assert ds_rst mid-cycle -> all outputs 0 immediately, reads of r1..r31 return 0.
REQ-022 SHALL check writeback bypass: write r5=0xDEADBEEF same cycle as decoding add r3,r5,r0 -> next cycle ds_o_data_rs=0xDEADBEEF.
REQ-023 SHALL check load-use: lw r2,4(r1) then add r4,r2,r3 -> ds_o_stall=1 one cycle, one bubble (ds_o_ce=0), add issued next cycle.
REQ-024 SHALL check no false stall: lw r2 then sw... using rs=r1, rt=r2? -> stall; lw r0 then add r4,r0,r0 -> no stall.
REQ-025 SHALL check flush+stall coincident: load-use pair with ds_i_flush=1 -> ds_o_stall=0, bubble issued.
REQ-026 SHALL check jal: instr 0x0C000010 -> ds_o_jal=1, ds_o_addr_rd=31, ds_o_jal_addr=0x10, ds_o_reg_wr=1.

Source files
------------

// File: rtl/decode_stage_hz_pkg.sv
// decode_stage_hz_pkg: MIPS-I opcode/funct constants, field widths and control bundle for the decode stage
package decode_stage_hz_pkg;
  localparam int OP_W = 6;
  localparam int FN_W = 6;
  localparam int IMM_W = 16;
  localparam int JA_W = 26;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_JAL = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OP_W-1:0] OP_LW = 6'h23;
  localparam logic [OP_W-1:0] OP_SW = 6'h2B;
  localparam logic [FN_W-1:0] FN_JR = 6'h08;

  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_e;

  typedef struct packed {
    logic reg_wr;
    logic memwrite;
    logic memtoreg;
    logic alu_src;
    logic branch;
    logic jal;
    logic jr;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Only these formats consume rt as a source operand, so only they can hit a load-use on rt
  function automatic logic reads_rt(input logic [OP_W-1:0] op);
    return op == OP_RTYPE || op == OP_BEQ || op == OP_SW;
  endfunction
endpackage

// File: rtl/decode_stage_hz_if.sv
// decode_stage_hz_if: fetch/writeback inputs and ID/EX outputs of the decode stage
interface decode_stage_hz_if #(
  parameter int DWIDTH = 32,
  parameter int NREGS = 32,
  parameter int IWIDTH = 32
);
  localparam int AWIDTH = $clog2(NREGS);
  logic ds_i_ce;
  logic [IWIDTH-1:0] ds_i_instr;
  logic ds_i_flush;
  logic ds_i_reg_wr;
  logic [AWIDTH-1:0] ds_i_addr_rd;
  logic [DWIDTH-1:0] ds_i_data_rd;
  logic ds_o_stall;
  logic ds_o_ce;
  logic [5:0] ds_o_opcode;
  logic [5:0] ds_o_funct;
  logic [DWIDTH-1:0] ds_o_data_rs;
  logic [DWIDTH-1:0] ds_o_data_rt;
  logic [AWIDTH-1:0] ds_o_addr_rs;
  logic [AWIDTH-1:0] ds_o_addr_rt;
  logic [AWIDTH-1:0] ds_o_addr_rd;
  logic [DWIDTH-1:0] ds_o_imm;
  logic [25:0] ds_o_jal_addr;
  logic ds_o_reg_wr;
  logic ds_o_memwrite;
  logic ds_o_memtoreg;
  logic ds_o_alu_src;
  logic ds_o_branch;
  logic ds_o_jal;
  logic ds_o_jr;

  modport master (
    output ds_i_ce, ds_i_instr, ds_i_flush, ds_i_reg_wr, ds_i_addr_rd, ds_i_data_rd,
    input ds_o_stall, ds_o_ce, ds_o_opcode, ds_o_funct, ds_o_data_rs, ds_o_data_rt,
    input ds_o_addr_rs, ds_o_addr_rt, ds_o_addr_rd, ds_o_imm, ds_o_jal_addr,
    input ds_o_reg_wr, ds_o_memwrite, ds_o_memtoreg, ds_o_alu_src, ds_o_branch, ds_o_jal, ds_o_jr
  );

  modport slave (
    input ds_i_ce, ds_i_instr, ds_i_flush, ds_i_reg_wr, ds_i_addr_rd, ds_i_data_rd,
    output ds_o_stall, ds_o_ce, ds_o_opcode, ds_o_funct, ds_o_data_rs, ds_o_data_rt,
    output ds_o_addr_rs, ds_o_addr_rt, ds_o_addr_rd, ds_o_imm, ds_o_jal_addr,
    output ds_o_reg_wr, ds_o_memwrite, ds_o_memtoreg, ds_o_alu_src, ds_o_branch, ds_o_jal, ds_o_jr
  );
endinterface

// File: rtl/decode_stage_hz_ctrl_decode.sv
// ds_ctrl_decode: main control, destination select and immediate sign extension
module ds_ctrl_decode
  import decode_stage_hz_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input logic [OP_W-1:0] opcode,
  input logic [FN_W-1:0] funct,
  input logic [IMM_W-1:0] imm16,
  output ctrl_t ctrl,
  output dst_e dst,
  output logic uses_rt,
  output logic [DWIDTH-1:0] imm
);
  always_comb begin
    ctrl = CTRL_NONE;
    dst = DST_RT;
    case (opcode)
      OP_RTYPE: begin
        ctrl.jr = funct == FN_JR;
        ctrl.reg_wr = funct != FN_JR;
        dst = DST_RD;
      end
      OP_LW: begin
        ctrl.memtoreg = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.reg_wr = 1'b1;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alu_src = 1'b1;
      end
      OP_BEQ: ctrl.branch = 1'b1;
      OP_ADDI: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_wr = 1'b1;
      end
      OP_JAL: begin
        ctrl.jal = 1'b1;
        ctrl.reg_wr = 1'b1;
        dst = DST_RA;
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

  assign uses_rt = reads_rt(opcode);
  assign imm = {{(DWIDTH-IMM_W){imm16[IMM_W-1]}}, imm16};
endmodule

// File: rtl/decode_stage_hz.sv
// decode_stage_hz: MIPS-I decode with register file, writeback bypass, load-use stall and ID/EX register
module decode_stage_hz
  import decode_stage_hz_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NREGS = 32,
  parameter int IWIDTH = 32
) (
  input logic ds_clk,
  input logic ds_rst,
  decode_stage_hz_if.slave bus
);
  localparam int AWIDTH = $clog2(NREGS);

  typedef struct packed {
    logic ce;
    logic [OP_W-1:0] opcode;
    logic [FN_W-1:0] funct;
    logic [DWIDTH-1:0] data_rs;
    logic [DWIDTH-1:0] data_rt;
    logic [DWIDTH-1:0] imm;
    logic [AWIDTH-1:0] addr_rs;
    logic [AWIDTH-1:0] addr_rt;
    logic [AWIDTH-1:0] addr_rd;
    logic [JA_W-1:0] jal_addr;
    ctrl_t ctrl;
  } idex_t;

  logic [IWIDTH-1:0] instr;
  logic [AWIDTH-1:0] rs, rt, rd, dest;
  logic [DWIDTH-1:0] data_rs, data_rt, imm;
  logic [DWIDTH-1:0] regs [NREGS];
  ctrl_t ctrl;
  dst_e dst;
  logic uses_rt, hz, bubble;
  idex_t idex, idex_d;

  assign instr = bus.ds_i_instr;
  assign rs = instr[21 +: AWIDTH];
  assign rt = instr[16 +: AWIDTH];
  assign rd = instr[11 +: AWIDTH];

  ds_ctrl_decode #(.DWIDTH(DWIDTH)) u_ctrl (
    .opcode(instr[31:26]),
    .funct(instr[5:0]),
    .imm16(instr[15:0]),
    .ctrl(ctrl),
    .dst(dst),
    .uses_rt(uses_rt),
    .imm(imm)
  );

  assign dest = dst == DST_RD ? rd : dst == DST_RA ? AWIDTH'(NREGS - 1) : rt;

  always_ff @(posedge ds_clk or posedge ds_rst)
    if (ds_rst) regs <= '{default: '0};
    else if (bus.ds_i_reg_wr && bus.ds_i_addr_rd != '0) regs[bus.ds_i_addr_rd] <= bus.ds_i_data_rd;

  // Writeback in the same cycle is forwarded so decode never sees a stale operand
  assign data_rs = rs == '0 ? '0 : (bus.ds_i_reg_wr && bus.ds_i_addr_rd == rs) ? bus.ds_i_data_rd : regs[rs];
  assign data_rt = rt == '0 ? '0 : (bus.ds_i_reg_wr && bus.ds_i_addr_rd == rt) ? bus.ds_i_data_rd : regs[rt];

  // Load in ID/EX feeding the instruction now in decode cannot be forwarded in time
  assign hz = bus.ds_i_ce && idex.ce && idex.ctrl.memtoreg && idex.addr_rd != '0 &&
              (idex.addr_rd == rs || (uses_rt && idex.addr_rd == rt));
  assign bus.ds_o_stall = hz && !bus.ds_i_flush && !ds_rst;
  assign bubble = !bus.ds_i_ce || bus.ds_i_flush || hz;

  always_comb begin
    idex_d = '0;
    if (!bubble)
      idex_d = '{ce: 1'b1, opcode: instr[31:26], funct: instr[5:0], data_rs: data_rs, data_rt: data_rt,
                 imm: imm, addr_rs: rs, addr_rt: rt, addr_rd: dest, jal_addr: instr[25:0], ctrl: ctrl};
  end

  always_ff @(posedge ds_clk or posedge ds_rst)
    if (ds_rst) idex <= '0;
    else idex <= idex_d;

  assign bus.ds_o_ce = idex.ce;
  assign bus.ds_o_opcode = idex.opcode;
  assign bus.ds_o_funct = idex.funct;
  assign bus.ds_o_data_rs = idex.data_rs;
  assign bus.ds_o_data_rt = idex.data_rt;
  assign bus.ds_o_addr_rs = idex.addr_rs;
  assign bus.ds_o_addr_rt = idex.addr_rt;
  assign bus.ds_o_addr_rd = idex.addr_rd;
  assign bus.ds_o_imm = idex.imm;
  assign bus.ds_o_jal_addr = idex.jal_addr;
  assign bus.ds_o_reg_wr = idex.ctrl.reg_wr;
  assign bus.ds_o_memwrite = idex.ctrl.memwrite;
  assign bus.ds_o_memtoreg = idex.ctrl.memtoreg;
  assign bus.ds_o_alu_src = idex.ctrl.alu_src;
  assign bus.ds_o_branch = idex.ctrl.branch;
  assign bus.ds_o_jal = idex.ctrl.jal;
  assign bus.ds_o_jr = idex.ctrl.jr;
endmodule
